// File: rtl/i2c_seq_pkg.sv
// Shared state encoding and widths for the I2C write sequencer and its byte FIFO.
package i2c_seq_pkg;

  localparam int BYTE_W  = 8;
  localparam int ENTRY_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_ACK,
    WAIT_REL,
    FLUSH
  } state_t;

endpackage

// File: rtl/i2c_byte_fifo.sv
// First-word fall-through FIFO holding {last, data} entries for the sequencer.
module i2c_byte_fifo
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // A flush discards everything, including a push that lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/i2c_wr_sequencer.sv
// Buffers host write transactions and hands them byte by byte to the I2C byte sender.
module i2c_wr_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [BYTE_W-1:0]             wr_data,
  input  logic                          wr_last,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          txn_done,
  output logic                          err_nack,
  output logic                          err_timeout,
  output logic                          err_ovf,
  input  logic                          clr_err,
  output logic                          pre_ready,
  output logic [BYTE_W-1:0]             pre_data,
  input  logic                          byte_done,
  input  logic                          byte_nack
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] CNT_ONE   = 1;
  localparam logic [15:0]   TMO_LIMIT = 16'(TIMEOUT_CYC);

  state_t             state;
  logic [ENTRY_W-1:0] head;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               fifo_flush;
  logic               push_last;
  logic               pop_last;
  logic [LW-1:0]      txn_cnt;
  logic [15:0]        tmo_cnt;
  logic               timed_out;
  logic               cur_last;
  logic               done_q;
  logic               rise;
  logic               fall;

  i2c_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   ({wr_last, wr_data}),
    .dout  (head),
    .full  (full),
    .empty (fifo_empty),
    .level (level)
  );

  // A full FIFO with no complete transaction can never drain on its own.
  assign fifo_flush = (state == IDLE) && full && (txn_cnt == '0);
  assign fifo_pop   = (state == LOAD) ||
                      ((state == FLUSH) && !cur_last && !fifo_empty);
  assign push_last  = wr_en & ~full & wr_last;
  assign pop_last   = fifo_pop & head[ENTRY_W-1];
  assign rise       = byte_done & ~done_q;
  assign fall       = ~byte_done & done_q;
  assign timed_out  = (tmo_cnt == TMO_LIMIT);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
    end else if (fifo_flush) begin
      txn_cnt <= '0;
    end else begin
      case ({push_last, pop_last})
        2'b10:   txn_cnt <= txn_cnt + CNT_ONE;
        2'b01:   txn_cnt <= txn_cnt - CNT_ONE;
        default: txn_cnt <= txn_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pre_ready   <= 1'b0;
      pre_data    <= '0;
      cur_last    <= 1'b0;
      txn_done    <= 1'b0;
      tmo_cnt     <= '0;
      done_q      <= 1'b0;
      err_nack    <= 1'b0;
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      done_q    <= byte_done;
      pre_ready <= 1'b0;
      txn_done  <= 1'b0;
      if ((wr_en && full) || fifo_flush) err_ovf <= 1'b1;

      case (state)
        IDLE: begin
          if (txn_cnt != '0) state <= LOAD;
        end
        LOAD: begin
          pre_data  <= head[BYTE_W-1:0];
          cur_last  <= head[ENTRY_W-1];
          pre_ready <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
          if (rise) begin
            if (byte_nack) begin
              err_nack <= 1'b1;
              state    <= FLUSH;
            end else begin
              tmo_cnt <= '0;
              state   <= WAIT_REL;
            end
          end else if (timed_out) begin
            err_timeout <= 1'b1;
            state       <= FLUSH;
          end
        end
        WAIT_REL: begin
          if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
          if (fall) begin
            if (cur_last) begin
              txn_done <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= LOAD;
            end
          end else if (timed_out) begin
            err_timeout <= 1'b1;
            state       <= FLUSH;
          end
        end
        FLUSH: begin
          // The remainder of the failed transaction is fully buffered, so stop at its last entry.
          if (cur_last || fifo_empty || head[ENTRY_W-1]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (clr_err) begin
        err_nack    <= 1'b0;
        err_timeout <= 1'b0;
        err_ovf     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_wr_sequencer.sv
// Directed self-checking bench for i2c_wr_sequencer with a small byte-sender model.
module tb_i2c_wr_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       full;
  logic [2:0] level;
  logic       busy;
  logic       txn_done;
  logic       err_nack;
  logic       err_timeout;
  logic       err_ovf;
  logic       clr_err;
  logic       pre_ready;
  logic [7:0] pre_data;
  logic       byte_done;
  logic       byte_nack;

  int n_checks = 0;
  int n_pass = 0;
  int pr_count = 0;
  int done_count = 0;

  i2c_wr_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .full        (full),
    .level       (level),
    .busy        (busy),
    .txn_done    (txn_done),
    .err_nack    (err_nack),
    .err_timeout (err_timeout),
    .err_ovf     (err_ovf),
    .clr_err     (clr_err),
    .pre_ready   (pre_ready),
    .pre_data    (pre_data),
    .byte_done   (byte_done),
    .byte_nack   (byte_nack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pre_ready === 1'b1) pr_count++;
    if (txn_done === 1'b1) done_count++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push1(input logic [7:0] d, input logic l);
    wr_en = 1'b1; wr_data = d; wr_last = l;
    @(negedge clk);
  endtask

  task automatic push_idle();
    wr_en = 1'b0; wr_data = 8'h00; wr_last = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // Waits for pre_ready, captures pre_data, then ACKs or NACKs it with a 3-cycle byte_done.
  task automatic serve_byte(input logic nack, output logic [7:0] data, output int waited);
    waited = 0;
    while (pre_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (pre_ready !== 1'b1) begin
      $display("[TB] FAIL serve_wait: pre_ready=%b after %0d cycles, required 1", pre_ready, waited);
      data = 8'hxx;
      return;
    end
    n_pass++;
    data = pre_data;
    @(negedge clk);
    n_checks++;
    if (pre_ready !== 1'b0) $display("[TB] FAIL pre_ready_width: got %b required 0", pre_ready);
    else n_pass++;
    @(negedge clk);
    byte_done = 1'b1; byte_nack = nack;
    repeat (3) @(negedge clk);
    if (!nack) begin
      n_checks++;
      if (pre_data !== data) $display("[TB] FAIL pre_data_hold: got %h required %h", pre_data, data);
      else n_pass++;
    end
    byte_done = 1'b0; byte_nack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (level !== 3'd0) $display("[TB] FAIL reset_level: got %0d required 0", level);
    else n_pass++;
    n_checks++;
    if ({busy, full, pre_ready, txn_done} !== 4'b0)
      $display("[TB] FAIL reset_ctrl: got %b required 0000", {busy, full, pre_ready, txn_done});
    else n_pass++;
    n_checks++;
    if ({err_nack, err_timeout, err_ovf} !== 3'b0)
      $display("[TB] FAIL reset_err: got %b required 000", {err_nack, err_timeout, err_ovf});
    else n_pass++;
    n_checks++;
    if (pre_data !== 8'h00) $display("[TB] FAIL reset_pre_data: got %h required 00", pre_data);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] d;
    int w;
    int pr0, dc0;
    pr0 = pr_count; dc0 = done_count;
    push1(8'hA0, 1'b0); push1(8'h10, 1'b0); push1(8'h5A, 1'b1); push_idle();
    n_checks++;
    if (level !== 3'd3 || busy !== 1'b0)
      $display("[TB] FAIL single_buffered: level=%0d busy=%b required level=3 busy=0", level, busy);
    else n_pass++;
    serve_byte(1'b0, d, w);
    n_checks++;
    if (d !== 8'hA0) $display("[TB] FAIL single_b0: got %h required a0", d); else n_pass++;
    n_checks++;
    if (w !== 2) $display("[TB] FAIL single_first_latency: got %0d required 2", w); else n_pass++;
    serve_byte(1'b0, d, w);
    n_checks++;
    if (d !== 8'h10) $display("[TB] FAIL single_b1: got %h required 10", d); else n_pass++;
    n_checks++;
    if (w !== 2) $display("[TB] FAIL single_b2b_latency: got %0d required 2", w); else n_pass++;
    serve_byte(1'b0, d, w);
    n_checks++;
    if (d !== 8'h5A) $display("[TB] FAIL single_b2: got %h required 5a", d); else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_count - dc0 !== 1) $display("[TB] FAIL single_txn_done: got %0d pulses required 1", done_count - dc0);
    else n_pass++;
    n_checks++;
    if (pr_count - pr0 !== 3) $display("[TB] FAIL single_pre_ready: got %0d pulses required 3", pr_count - pr0);
    else n_pass++;
    n_checks++;
    if (level !== 3'd0 || busy !== 1'b0)
      $display("[TB] FAIL single_end: level=%0d busy=%b required 0 0", level, busy);
    else n_pass++;
  endtask

  task automatic test_incomplete();
    logic [7:0] exp_d [3];
    logic [7:0] d;
    int w;
    int pr0, dc0;
    exp_d = '{8'hA0, 8'h10, 8'h33};
    pr0 = pr_count; dc0 = done_count;
    push1(8'hA0, 1'b0); push1(8'h10, 1'b0); push_idle();
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || pr_count - pr0 !== 0 || level !== 3'd2)
      $display("[TB] FAIL incomplete_hold: busy=%b pulses=%0d level=%0d required 0 0 2", busy, pr_count - pr0, level);
    else n_pass++;
    push1(8'h33, 1'b1); push_idle();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("[TB] FAIL incomplete_start_busy: got %b required 1", busy); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (pre_ready !== 1'b1) $display("[TB] FAIL incomplete_start_ready: got %b required 1", pre_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      serve_byte(1'b0, d, w);
      n_checks++;
      if (d !== exp_d[i]) $display("[TB] FAIL incomplete_b%0d: got %h required %h", i, d, exp_d[i]);
      else n_pass++;
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_count - dc0 !== 1) $display("[TB] FAIL incomplete_txn_done: got %0d required 1", done_count - dc0);
    else n_pass++;
  endtask

  task automatic test_nack();
    logic [7:0] d;
    int w;
    int pr0, dc0;
    pr0 = pr_count; dc0 = done_count;
    push1(8'hA0, 1'b0); push1(8'h10, 1'b0); push1(8'h5A, 1'b1); push1(8'hB0, 1'b1); push_idle();
    serve_byte(1'b0, d, w);
    n_checks++;
    if (d !== 8'hA0) $display("[TB] FAIL nack_b0: got %h required a0", d); else n_pass++;
    serve_byte(1'b1, d, w);
    n_checks++;
    if (d !== 8'h10) $display("[TB] FAIL nack_b1: got %h required 10", d); else n_pass++;
    n_checks++;
    if (err_nack !== 1'b1) $display("[TB] FAIL nack_flag: got %b required 1", err_nack); else n_pass++;
    serve_byte(1'b0, d, w);
    n_checks++;
    if (d !== 8'hB0) $display("[TB] FAIL nack_next_txn: got %h required b0", d); else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_count - dc0 !== 1 || pr_count - pr0 !== 3)
      $display("[TB] FAIL nack_counts: done=%0d ready=%0d required 1 3", done_count - dc0, pr_count - pr0);
    else n_pass++;
    n_checks++;
    if (level !== 3'd0 || busy !== 1'b0 || err_nack !== 1'b1)
      $display("[TB] FAIL nack_end: level=%0d busy=%b err_nack=%b required 0 0 1", level, busy, err_nack);
    else n_pass++;
    pulse_clr();
    n_checks++;
    if (err_nack !== 1'b0) $display("[TB] FAIL nack_clear: got %b required 0", err_nack); else n_pass++;
  endtask

  task automatic test_timeout();
    int w;
    int pr0;
    pr0 = pr_count;
    push1(8'hC1, 1'b0); push1(8'hC2, 1'b1); push_idle();
    w = 0;
    while (pre_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (pre_ready !== 1'b1) $display("[TB] FAIL tmo_issue: pre_ready=%b required 1", pre_ready); else n_pass++;
    repeat (21) @(negedge clk);
    n_checks++;
    if (err_timeout !== 1'b0) $display("[TB] FAIL tmo_early: got %b required 0", err_timeout); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b1)
      $display("[TB] FAIL tmo_set: err_timeout=%b busy=%b required 1 1", err_timeout, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (level !== 3'd0 || busy !== 1'b0)
      $display("[TB] FAIL tmo_flush: level=%0d busy=%b required 0 0", level, busy);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pr_count - pr0 !== 1) $display("[TB] FAIL tmo_ready_count: got %0d required 1", pr_count - pr0);
    else n_pass++;
    pulse_clr();
    n_checks++;
    if (err_timeout !== 1'b0) $display("[TB] FAIL tmo_clear: got %b required 0", err_timeout); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_d [4];
    logic [7:0] d;
    int w;
    int pr0, dc0;
    exp_d = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    pr0 = pr_count;
    for (int i = 0; i < 4; i++) push1(8'h60 + 8'(i), 1'b0);
    push_idle();
    n_checks++;
    if (level !== 3'd4 || full !== 1'b1)
      $display("[TB] FAIL ovf_fill: level=%0d full=%b required 4 1", level, full);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (level !== 3'd0 || err_ovf !== 1'b1 || full !== 1'b0)
      $display("[TB] FAIL ovf_flush: level=%0d err_ovf=%b full=%b required 0 1 0", level, err_ovf, full);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || pr_count - pr0 !== 0)
      $display("[TB] FAIL ovf_idle: busy=%b pulses=%0d required 0 0", busy, pr_count - pr0);
    else n_pass++;
    pulse_clr();
    n_checks++;
    if (err_ovf !== 1'b0) $display("[TB] FAIL ovf_clear: got %b required 0", err_ovf); else n_pass++;

    for (int i = 0; i < 4; i++) push1(8'h70 + 8'(i), 1'b0);
    push_idle();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_checks++;
    if (err_ovf !== 1'b0 || level !== 3'd0)
      $display("[TB] FAIL ovf_clr_priority: err_ovf=%b level=%0d required 0 0", err_ovf, level);
    else n_pass++;

    pr0 = pr_count; dc0 = done_count;
    push1(8'hD0, 1'b0); push1(8'hD1, 1'b0); push1(8'hD2, 1'b0); push1(8'hD3, 1'b1);
    push1(8'hE5, 1'b1); push_idle();
    n_checks++;
    if (err_ovf !== 1'b1 || level !== 3'd4)
      $display("[TB] FAIL ovf_drop: err_ovf=%b level=%0d required 1 4", err_ovf, level);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      serve_byte(1'b0, d, w);
      n_checks++;
      if (d !== exp_d[i]) $display("[TB] FAIL ovf_b%0d: got %h required %h", i, d, exp_d[i]);
      else n_pass++;
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (done_count - dc0 !== 1 || pr_count - pr0 !== 4 || level !== 3'd0 || busy !== 1'b0)
      $display("[TB] FAIL ovf_drop_end: done=%0d ready=%0d level=%0d busy=%b required 1 4 0 0",
               done_count - dc0, pr_count - pr0, level, busy);
    else n_pass++;
    pulse_clr();
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int w;
    int dc0;
    push1(8'hF0, 1'b0); push1(8'hF1, 1'b1); push_idle();
    w = 0;
    while (pre_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || level !== 3'd1)
      $display("[TB] FAIL rst_mid_pre: busy=%b level=%0d required 1 1", busy, level);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, pre_ready, txn_done, full, err_nack, err_timeout, err_ovf} !== 7'b0 ||
        level !== 3'd0 || pre_data !== 8'h00)
      $display("[TB] FAIL rst_mid_outputs: ctrl=%b level=%0d pre_data=%h required 0 0 00",
               {busy, pre_ready, txn_done, full, err_nack, err_timeout, err_ovf}, level, pre_data);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dc0 = done_count;
    push1(8'h77, 1'b1); push_idle();
    serve_byte(1'b0, d, w);
    n_checks++;
    if (d !== 8'h77) $display("[TB] FAIL rst_mid_after: got %h required 77", d); else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_count - dc0 !== 1 || level !== 3'd0)
      $display("[TB] FAIL rst_mid_done: done=%0d level=%0d required 1 0", done_count - dc0, level);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; wr_last = 1'b0;
    clr_err = 1'b0; byte_done = 1'b0; byte_nack = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_incomplete();
    test_nack();
    test_timeout();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
